booth_mult_seq: RTL and testbench

- Sequencer for the radix-4 Booth multiply step datapath (combinational `step` block: takes current 65-bit product and multiplicand, returns next product already shifted right arithmetically by 2).
- Owns the product register, multiplicand register, iteration counter and handshake.
- Runs 16 step iterations per 32x32 signed multiply, then presents the low 32-bit result and an overflow flag.
- Sits inside the multdiv unit, between the pipeline's multiply-issue logic and the step datapath.

---
 rtl/booth_mult_seq_if.sv | 27 ++
 rtl/booth_mult_seq.sv | 77 +++++++
 tb/tb_booth_mult_seq.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/booth_mult_seq_if.sv
// Handshake and step-datapath bundle for booth_mult_seq.
// slave: sequencer side; master: issue logic plus step datapath side.
interface booth_mult_seq_if #(
    parameter int WIDTH = 32
);
    logic               start;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [2*WIDTH:0]   step_prod;
    logic [WIDTH-1:0]   step_mcand;
    logic [2:0]         step_opcode;
    logic [2*WIDTH:0]   step_next;
    logic [WIDTH-1:0]   result;
    logic               overflow;
    logic               ready;
    logic               busy;

    modport master (
        output start, op_a, op_b, step_next,
        input  step_prod, step_mcand, step_opcode, result, overflow, ready, busy
    );

    modport slave (
        input  start, op_a, op_b, step_next,
        output step_prod, step_mcand, step_opcode, result, overflow, ready, busy
    );
endinterface

// File: rtl/booth_mult_seq.sv
// Radix-4 Booth multiply sequencer: owns the product, multiplicand and iteration
// counter around an external step datapath. Option macro: MULT_ZERO_BYPASS_EN.
module booth_mult_seq #(
    parameter int WIDTH = 32,
    parameter int STEPS = 16
) (
    input logic             clock,
    input logic             reset,
    booth_mult_seq_if.slave bus
);
    localparam int CW = $clog2(STEPS) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [2*WIDTH:0] prod, prod_nxt;
    logic [WIDTH-1:0] mcand, mcand_nxt;
    logic [CW-1:0]    count, count_nxt;
    logic             load;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            prod  <= '0;
            mcand <= '0;
            count <= '0;
        end else begin
            state <= state_nxt;
            prod  <= prod_nxt;
            mcand <= mcand_nxt;
            count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        prod_nxt  = prod;
        mcand_nxt = mcand;
        count_nxt = count;
        load      = 1'b0;
        case (state)
            IDLE: load = bus.start;
            RUN: begin
                prod_nxt  = bus.step_next;
                count_nxt = count + CW'(1);
                if (count == CW'(STEPS - 1))
                    state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
                load      = bus.start;
            end
            default: state_nxt = IDLE;
        endcase
        // A start seen in DONE reloads directly, so back-to-back multiplies have no bubble.
        if (load) begin
            prod_nxt  = {{WIDTH{1'b0}}, bus.op_b, 1'b0};
            mcand_nxt = bus.op_a;
            count_nxt = '0;
            state_nxt = RUN;
`ifdef MULT_ZERO_BYPASS_EN
            if (bus.op_a == '0 || bus.op_b == '0) begin
                prod_nxt  = '0;
                state_nxt = DONE;
            end
`endif
        end
    end

    assign bus.step_prod   = prod;
    assign bus.step_mcand  = mcand;
    assign bus.step_opcode = prod[2:0];
    assign bus.result      = prod[WIDTH:1];
    assign bus.overflow    = (prod[2*WIDTH:WIDTH+1] != {WIDTH{prod[WIDTH]}});
    assign bus.ready       = (state == DONE);
    assign bus.busy        = (state == RUN);
endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq with a behavioural radix-4 step datapath.
// Honours MULT_ZERO_BYPASS_EN when compiled with it.
module tb_booth_mult_seq;
`ifdef MULT_ZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        int          rdy_cyc;
        int          busy_len;
    } exp_t;

    logic clock;
    logic reset;
    int   cyc;
    int   checks;
    int   failures;
    int   busy_cnt;
    exp_t exp_q[$];

    booth_mult_seq_if #(.WIDTH(32)) bus ();

    booth_mult_seq #(.WIDTH(32), .STEPS(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Step datapath: add the Booth-selected multiple of mcand to the upper half, then shift right by 2.
    function automatic logic [64:0] step_fn(input logic [64:0] p, input logic [31:0] m);
        logic signed [33:0] hi, mm, sum;
        logic signed [66:0] x;
        hi = {{2{p[64]}}, p[64:33]};
        mm = {{2{m[31]}}, m};
        case (p[2:0])
            3'b001, 3'b010: sum = hi + mm;
            3'b011:         sum = hi + (mm <<< 1);
            3'b100:         sum = hi - (mm <<< 1);
            3'b101, 3'b110: sum = hi - mm;
            default:        sum = hi;
        endcase
        x = {sum, p[32:0]};
        x = x >>> 2;
        return x[64:0];
    endfunction

    always_comb bus.step_next = step_fn(bus.step_prod, bus.step_mcand);

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops one expectation per ready pulse.
    initial begin
        exp_t e;
        busy_cnt = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                exp_q.delete();
                busy_cnt = 0;
            end else begin
                if (bus.busy) busy_cnt++;
                if (bus.ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_ready actual=1 required=0 (t=%0t)", $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("result",   65'(bus.result),   65'(e.res));
                        chk("overflow", 65'(bus.overflow), 65'(e.ovf));
                        chk("latency",  65'(cyc),          65'(e.rdy_cyc));
                        chk("busy_len", 65'(busy_cnt),     65'(e.busy_len));
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    // Drive a start (caller is at a negedge); returns the accepting edge number.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, output int n0);
        logic signed [63:0] sa, sb, p;
        bit   zb;
        exp_t e;
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        @(posedge clock);
        #1;
        n0 = cyc;
        bus.start = 1'b0;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        p  = sa * sb;
        zb = BYPASS && (a == 32'd0 || b == 32'd0);
        e.res      = p[31:0];
        e.ovf      = (p != {{32{p[31]}}, p[31:0]});
        e.rdy_cyc  = zb ? n0 : n0 + 16;
        e.busy_len = zb ? 0 : 16;
        exp_q.push_back(e);
        if (zb) begin
            chk("load_prod_zero", bus.step_prod, 65'd0);
        end else begin
            chk("load_prod",   bus.step_prod,       {32'd0, b, 1'b0});
            chk("load_mcand",  65'(bus.step_mcand), 65'(a));
            chk("load_opcode", 65'(bus.step_opcode), 65'({b[1:0], 1'b0}));
        end
    endtask

    task automatic mult(input logic [31:0] a, input logic [31:0] b, input bit noise, input bit b2b);
        int n0;
        bit got;
        got = 1'b0;
        issue(a, b, n0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bus.ready) begin
                got = 1'b1;
                break;
            end
            if (noise && cyc <= n0 + 14) begin
                bus.start = 1'($urandom_range(0, 1));
                bus.op_a  = $urandom;
                bus.op_b  = $urandom;
            end else begin
                bus.start = 1'b0;
            end
        end
        chk("ready_seen", 65'(got), 65'd1);
        bus.start = 1'b0;
        if (!b2b) repeat (3) @(negedge clock);
    endtask

    initial begin
        int n0;
        logic [31:0] a, b;
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        chk("rst_result",    65'(bus.result),   65'd0);
        chk("rst_overflow",  65'(bus.overflow), 65'd0);
        chk("rst_ready",     65'(bus.ready),    65'd0);
        chk("rst_busy",      65'(bus.busy),     65'd0);
        chk("rst_step_prod", bus.step_prod,     65'd0);

        mult(32'd7, 32'hFFFF_FFFD, 1'b0, 1'b0);
        mult(32'h0001_0000, 32'h0001_0000, 1'b0, 1'b1);
        mult(32'd3, 32'd4, 1'b0, 1'b0);
        mult(32'h0000_1234, 32'hFFFF_5678, 1'b1, 1'b0);

        // Abort mid-run: reset held across two edges so the monitor sees it.
        issue(32'd100, 32'd200, n0);
        repeat (8) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("abort_busy",      65'(bus.busy),   65'd0);
        chk("abort_ready",     65'(bus.ready),  65'd0);
        chk("abort_result",    65'(bus.result), 65'd0);
        chk("abort_step_prod", bus.step_prod,   65'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        mult(32'd5, 32'd5, 1'b0, 1'b0);
        mult(32'd0, 32'd123, 1'b0, 1'b0);
        mult(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
        mult(32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);
        mult(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);

        for (int i = 0; i < 25; i++) begin
            case ($urandom_range(0, 5))
                0:       a = 32'd0;
                1:       a = 32'h8000_0000;
                2:       a = 32'($urandom_range(0, 15)) - 32'd8;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'h7FFF_FFFF;
                2:       b = 32'($urandom_range(0, 15)) - 32'd8;
                default: b = $urandom;
            endcase
            mult(a, b, 1'($urandom_range(0, 1)), (i == 24) ? 1'b0 : 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clock);
        chk("queue_drained", 65'(exp_q.size()), 65'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
